pipeline_ctrl: RTL

Hazard and flow controller for the decode stage of the MINA2000 pipeline. It tracks destination registers in flight in EX and MEM and detects read-after-write hazards against the instruction in ID. It generates stall, bubble and flush controls for the IF/ID and ID/EX registers, sequences branch flushes and data-memory wait freezes, and keeps stall and flush cycle counters.

---
 rtl/pipeline_ctrl_if.sv | 37 +++
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Decode-stage hazard/flow control bundle for the MINA2000 pipeline.
// Carries the ID-stage operand/destination info, the EX branch and
// data-memory wait status (master -> slave) and the resulting stall/flush
// controls plus performance counters (slave -> master).
//   master : drives ID/EX/MEM status, observes controls and counters
//   slave  : the pipeline_ctrl block itself
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_ra_addr;
  logic [4:0]       id_rb_addr;
  logic             id_uses_ra;
  logic             id_uses_rb;
  logic [4:0]       id_rd_addr;
  logic             id_is_load;
  logic             ex_branch_taken;
  logic             mem_wait;
  logic             if_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_ra_addr, id_rb_addr, id_uses_ra, id_uses_rb,
           id_rd_addr, id_is_load, ex_branch_taken, mem_wait,
    input  if_hold, ifid_flush, idex_bubble, pipe_freeze, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_ra_addr, id_rb_addr, id_uses_ra, id_uses_rb,
           id_rd_addr, id_is_load, ex_branch_taken, mem_wait,
    output if_hold, ifid_flush, idex_bubble, pipe_freeze, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and flow controller for the MINA2000 decode stage.
// Tracks destinations in flight in EX and MEM, detects RAW hazards against
// the ID instruction and produces same-cycle stall/flush/freeze controls.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipeline_ctrl_if.slave (ID/EX/MEM status in, controls and
//                stall/flush cycle counters out)
// Priority of the controls: mem_wait > branch flush > hazard stall > run.
module pipeline_ctrl #(
  parameter int FWD_EN       = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipeline_ctrl_if.slave    bus
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Remaining flush cycles after the one in which the branch resolved.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state_q;
  logic [2:0]       fcnt_q;
  logic             ex_valid_q;
  logic [4:0]       ex_rd_q;
  logic             ex_load_q;
  logic             mem_valid_q;
  logic [4:0]       mem_rd_q;
  logic             mem_load_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic ex_hit_s;
  logic mem_hit_s;
  logic haz_s;
  logic flushing_s;
  logic if_hold_s;
  logic ifid_flush_s;
  logic idex_bubble_s;
  logic pipe_freeze_s;

  // A slot matches when it holds a live non-r0 destination read by ID.
  function automatic logic src_hit(
    input logic       valid,
    input logic [4:0] rd,
    input logic       uses_ra,
    input logic [4:0] ra,
    input logic       uses_rb,
    input logic [4:0] rb
  );
    return valid && (rd != 5'd0) &&
           ((uses_ra && (ra == rd)) || (uses_rb && (rb == rd)));
  endfunction

  // Hazard detection and same-cycle control generation.
  always_comb begin
    ex_hit_s      = src_hit(ex_valid_q, ex_rd_q, bus.id_uses_ra, bus.id_ra_addr,
                            bus.id_uses_rb, bus.id_rb_addr);
    mem_hit_s     = src_hit(mem_valid_q, mem_rd_q, bus.id_uses_ra, bus.id_ra_addr,
                            bus.id_uses_rb, bus.id_rb_addr);
    flushing_s    = bus.ex_branch_taken || (state_q == ST_FLUSH);
    if_hold_s     = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    pipe_freeze_s = 1'b0;

    // With forwarding, only a load in EX cannot supply its result in time.
    if (FWD_EN != 0) begin
      haz_s = bus.id_valid && ex_hit_s && ex_load_q;
    end else begin
      haz_s = bus.id_valid && (ex_hit_s || mem_hit_s);
    end

    if (!rst_n) begin
      if_hold_s = 1'b0;
    end else if (bus.mem_wait) begin
      pipe_freeze_s = 1'b1;
      if_hold_s     = 1'b1;
    end else if (flushing_s) begin
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
    end else if (haz_s) begin
      if_hold_s     = 1'b1;
      idex_bubble_s = 1'b1;
    end else begin
      if_hold_s = 1'b0;
    end
  end

  // Slot tracking, flush sequencing and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fcnt_q      <= 3'd0;
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_load_q  <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else if (!bus.mem_wait) begin
      mem_valid_q <= ex_valid_q;
      mem_rd_q    <= ex_rd_q;
      mem_load_q  <= ex_load_q;
      // rd=0 never produces a hazard, so it is tracked as an empty slot.
      if (bus.id_valid && !idex_bubble_s && (bus.id_rd_addr != 5'd0)) begin
        ex_valid_q <= 1'b1;
        ex_rd_q    <= bus.id_rd_addr;
        ex_load_q  <= bus.id_is_load;
      end else begin
        ex_valid_q <= 1'b0;
        ex_rd_q    <= 5'd0;
        ex_load_q  <= 1'b0;
      end

      case (state_q)
        ST_RUN: begin
          if (bus.ex_branch_taken && (FLUSH_CYCLES > 1)) begin
            state_q <= ST_FLUSH;
            fcnt_q  <= FLUSH_RELOAD;
          end
        end
        ST_FLUSH: begin
          // A branch seen here restarts the whole flush window.
          if (bus.ex_branch_taken) begin
            fcnt_q <= FLUSH_RELOAD;
          end else if (fcnt_q <= 3'd1) begin
            state_q <= ST_RUN;
            fcnt_q  <= 3'd0;
          end else begin
            fcnt_q <= fcnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          fcnt_q  <= 3'd0;
        end
      endcase

      if (flushing_s) begin
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (haz_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.if_hold     = if_hold_s;
  assign bus.ifid_flush  = ifid_flush_s;
  assign bus.idex_bubble = idex_bubble_s;
  assign bus.pipe_freeze = pipe_freeze_s;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule
